// File: rtl/hazard_unit_if.sv
// hazard_unit_if -- stage-register bundle between the pipeline datapath and
// the hazard unit.
//   master : datapath side, drives the ID/EX/MEM register numbers and
//            enables, receives the stall/flush controls.
//   slave  : hazard unit side.
// Signals:
//   ID_rs/ID_rt, ID_use_rs/ID_use_rt, ID_branch, ID_taken  (ID stage)
//   EX_RW, EX_regwe, EX_memread                             (EX stage)
//   MEM_RW, MEM_memread                                     (MEM stage)
//   PC_stall, IFID_stall, IFID_flush, IDEX_flush            (controls)
interface hazard_unit_if;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_use_rs;
    logic       ID_use_rt;
    logic       ID_branch;
    logic       ID_taken;
    logic [4:0] EX_RW;
    logic       EX_regwe;
    logic       EX_memread;
    logic [4:0] MEM_RW;
    logic       MEM_memread;
    logic       PC_stall;
    logic       IFID_stall;
    logic       IFID_flush;
    logic       IDEX_flush;

    modport master (
        output ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_branch, ID_taken,
        output EX_RW, EX_regwe, EX_memread, MEM_RW, MEM_memread,
        input  PC_stall, IFID_stall, IFID_flush, IDEX_flush
    );

    modport slave (
        input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_branch, ID_taken,
        input  EX_RW, EX_regwe, EX_memread, MEM_RW, MEM_memread,
        output PC_stall, IFID_stall, IFID_flush, IDEX_flush
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit -- load-use / ID-branch operand hazard detection and the
// PC hold, IF/ID hold/flush and ID/EX bubble controls.
// Ports:
//   clk        pipeline clock, rising edge
//   rst_n      synchronous reset, active-low (forces all outputs to 0)
//   bus        hazard_unit_if.slave (stage register numbers in, controls out)
//   stall_cnt  stall cycle count         (HAZARD_STAT_EN only)
//   flush_cnt  IF/ID flush cycle count   (HAZARD_STAT_EN only)
// Configuration macro: HAZARD_STAT_EN enables the two statistics counters,
// STAT_W bits wide, wrapping. Without it STAT_W is unused.
module hazard_unit #(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_unit_if.slave      bus
`ifdef HAZARD_STAT_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
`endif
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t     r_state;
    logic       r_remain;

    logic       w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
    logic       w_ex_match, w_mem_match;
    logic [1:0] w_depth;
    logic       w_stall;
    logic       w_flush;
    logic       w_remain_dec;

    // A source matches only when it is actually read and is not $0.
    assign w_rs_ex  = bus.ID_use_rs && (bus.ID_rs != 5'd0) && (bus.ID_rs == bus.EX_RW);
    assign w_rt_ex  = bus.ID_use_rt && (bus.ID_rt != 5'd0) && (bus.ID_rt == bus.EX_RW);
    assign w_rs_mem = bus.ID_use_rs && (bus.ID_rs != 5'd0) && (bus.ID_rs == bus.MEM_RW);
    assign w_rt_mem = bus.ID_use_rt && (bus.ID_rt != 5'd0) && (bus.ID_rt == bus.MEM_RW);
    // rs and rt naming the same register still yields a single match.
    assign w_ex_match  = w_rs_ex  || w_rt_ex;
    assign w_mem_match = w_rs_mem || w_rt_mem;

    // Required stall depth; the load case is tested first so it wins.
    always_comb begin
        w_depth = 2'd0;
        if (bus.EX_memread && w_ex_match)
            w_depth = bus.ID_branch ? 2'd2 : 2'd1;
        else if (bus.EX_regwe && w_ex_match && bus.ID_branch)
            w_depth = 2'd1;
        else if (bus.MEM_memread && w_mem_match && bus.ID_branch)
            w_depth = 2'd1;
    end

    // HOLD stalls without looking at the inputs again.
    assign w_stall = rst_n && (((r_state == RUN) && (w_depth != 2'd0)) || (r_state == HOLD));
    // A taken branch seen during a stall has stale operands; drop it.
    assign w_flush = rst_n && bus.ID_taken && !w_stall;

    assign bus.PC_stall   = w_stall;
    assign bus.IFID_stall = w_stall;
    assign bus.IDEX_flush = w_stall;
    assign bus.IFID_flush = w_flush;

    // Down-count that never wraps below zero.
    assign w_remain_dec = (r_remain == 1'b0) ? 1'b0 : (r_remain - 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_remain <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_depth == 2'd2) begin
                        r_remain <= 1'b1;
                        r_state  <= HOLD;
                    end
                end
                HOLD: begin
                    r_remain <= w_remain_dec;
                    if (w_remain_dec == 1'b0)
                        r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STAT_EN
    logic [STAT_W-1:0] r_stall_cnt;
    logic [STAT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit -- directed bench for hazard_unit. Expected control vectors
// {PC_stall, IFID_stall, IFID_flush, IDEX_flush} are queued as each step is
// driven and popped when the outputs are sampled on the falling edge. With
// HAZARD_STAT_EN the counters are checked against bench-side tallies.
module tb_hazard_unit;
    localparam int SW = 4;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [3:0]    q[$];
    logic [SW-1:0] exp_sc = '0;
    logic [SW-1:0] exp_fc = '0;

    hazard_unit_if bus ();

`ifdef HAZARD_STAT_EN
    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] flush_cnt;
    hazard_unit #(.STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
`else
    hazard_unit #(.STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive, queue expectation, sample at negedge, then
    // cross the rising edge and check the counters.
    task automatic step(input string tag, input logic rstv,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic br, input logic tk,
                        input logic [4:0] exrw, input logic exwe, input logic exmr,
                        input logic [4:0] memrw, input logic memmr,
                        input logic [3:0] expv);
        logic [3:0] e;
        rst_n           = rstv;
        bus.ID_rs       = rs;
        bus.ID_rt       = rt;
        bus.ID_use_rs   = urs;
        bus.ID_use_rt   = urt;
        bus.ID_branch   = br;
        bus.ID_taken    = tk;
        bus.EX_RW       = exrw;
        bus.EX_regwe    = exwe;
        bus.EX_memread  = exmr;
        bus.MEM_RW      = memrw;
        bus.MEM_memread = memmr;
        q.push_back(expv);
        @(negedge clk);
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = q.pop_front();
            check4(tag, {bus.PC_stall, bus.IFID_stall, bus.IFID_flush, bus.IDEX_flush}, e);
            if (!rstv) begin
                exp_sc = '0;
                exp_fc = '0;
            end else begin
                exp_sc = exp_sc + SW'(e[3]);
                exp_fc = exp_fc + SW'(e[1]);
            end
        end
        @(posedge clk);
        #1;
`ifdef HAZARD_STAT_EN
        total++;
        assert (stall_cnt === exp_sc) else begin
            bad++;
            $error("FAIL %s_stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp_sc);
        end
        total++;
        assert (flush_cnt === exp_fc) else begin
            bad++;
            $error("FAIL %s_flush_cnt observed=%0d expected=%0d", tag, flush_cnt, exp_fc);
        end
`endif
    endtask

    initial begin
        //    tag          rst rs  rt  urs urt br tk exrw we mr  memrw mr  exp
        step("reset",      0, 8,  0,  1,  0,  1, 1, 8,  1, 1, 0,  0, 4'b0000);
        step("idle",       1, 0,  0,  0,  0,  0, 0, 0,  0, 0, 0,  0, 4'b0000);
        // load-use, ALU consumer: one stall then proceed
        step("ld_use",     1, 8,  0,  1,  0,  0, 0, 8,  1, 1, 0,  0, 4'b1101);
        step("ld_use_go",  1, 1,  2,  1,  1,  0, 0, 8,  1, 0, 8,  1, 4'b0000);
        // load feeding a branch: two stalls; second cycle ignores inputs
        step("ld_br_1",    1, 0,  9,  0,  1,  1, 0, 9,  1, 1, 0,  0, 4'b1101);
        step("ld_br_2",    1, 3,  4,  0,  0,  0, 1, 0,  0, 0, 9,  1, 4'b1101);
        step("ld_br_go",   1, 0,  9,  0,  1,  1, 0, 0,  0, 0, 9,  0, 4'b0000);
        // ALU result feeding a branch
        step("alu_br",     1, 3,  0,  1,  0,  1, 0, 3,  1, 0, 0,  0, 4'b1101);
        step("alu_nobr",   1, 3,  0,  1,  0,  0, 0, 3,  1, 0, 0,  0, 4'b0000);
        step("reg0",       1, 0,  0,  1,  1,  1, 0, 0,  1, 1, 0,  1, 4'b0000);
        step("unused_src", 1, 8,  8,  0,  0,  0, 0, 8,  1, 1, 0,  0, 4'b0000);
        // MEM load only blocks an ID branch
        step("mem_ld_br",  1, 0,  5,  0,  1,  1, 0, 0,  0, 0, 5,  1, 4'b1101);
        step("mem_ld_alu", 1, 0,  5,  0,  1,  0, 0, 0,  0, 0, 5,  1, 4'b0000);
        step("rs_eq_rt",   1, 7,  7,  1,  1,  0, 0, 7,  1, 1, 0,  0, 4'b1101);
        step("rs_eq_rt_go",1, 7,  7,  1,  1,  0, 0, 0,  0, 0, 7,  1, 4'b0000);
        // taken-branch squash, suppressed while stalled
        step("taken",      1, 0,  0,  0,  0,  1, 1, 0,  0, 0, 0,  0, 4'b0010);
        step("taken_st1",  1, 4,  0,  1,  0,  1, 1, 4,  1, 1, 0,  0, 4'b1101);
        step("taken_st2",  1, 4,  0,  1,  0,  1, 1, 0,  0, 0, 4,  1, 4'b1101);
        step("taken_after",1, 4,  0,  1,  0,  1, 1, 0,  0, 0, 0,  0, 4'b0010);
        // reset landing on the HOLD cycle abandons the stall
        step("hold_enter", 1, 6,  0,  1,  0,  1, 0, 6,  1, 1, 0,  0, 4'b1101);
        step("hold_rst",   0, 6,  0,  1,  0,  1, 1, 6,  1, 1, 0,  0, 4'b0000);
        step("post_rst",   1, 0,  0,  0,  0,  0, 0, 0,  0, 0, 0,  0, 4'b0000);
        // 17 single-cycle stalls from a fresh count
        for (int i = 0; i < 17; i++)
            step("stall_run", 1, 2, 0, 1, 0, 0, 0, 2, 1, 1, 0, 0, 4'b1101);
`ifdef HAZARD_STAT_EN
        total++;
        assert (stall_cnt === 4'd1) else begin
            bad++;
            $error("FAIL stall_wrap observed=%0d expected=1", stall_cnt);
        end
`endif
        step("final",      1, 0,  0,  0,  0,  0, 0, 0,  0, 0, 0,  0, 4'b0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard detection and stall/flush control for the five-stage pipeline. It covers the data hazards that forwarding cannot resolve: load-use, and ID-stage branch/jr operand dependencies. It also squashes the fetched instruction after a taken branch. It sits beside the forwarding logic, takes the same stage register numbers and write enables, and drives PC hold, IF/ID hold/flush and ID/EX bubble insertion.

## Interface
Parameters:
- STAT_W, 32, width of the statistics counters (only with HAZARD_STAT_EN)

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- ID_rs  input  5  rs of the instruction in ID
- ID_rt  input  5  rt of the instruction in ID
- ID_use_rs  input  1  ID instruction reads rs
- ID_use_rt  input  1  ID instruction reads rt
- ID_branch  input  1  ID instruction is a branch or jr that compares/reads operands in ID
- ID_taken  input  1  ID branch/jump resolved taken this cycle
- EX_RW  input  5  destination register in EX
- EX_regwe  input  1  EX writes a register
- EX_memread  input  1  EX instruction is a load
- MEM_RW  input  5  destination register in MEM
- MEM_memread  input  1  MEM instruction is a load
- PC_stall  output  1  hold PC
- IFID_stall  output  1  hold IF/ID register
- IFID_flush  output  1  clear IF/ID register (taken branch squash)
- IDEX_flush  output  1  insert bubble into ID/EX
- stall_cnt  output  STAT_W  total stall cycles (HAZARD_STAT_EN only)
- flush_cnt  output  STAT_W  total IFID_flush cycles (HAZARD_STAT_EN only)

## Operation
- A source matches a stage when it is used, its register is nonzero, and it equals that stage's destination register.
- Required stall depth D, evaluated only in state RUN; the largest applicable value wins:
  - EX load, matched by ID source, ID_branch=1: D=2
  - EX load, matched by ID source, ID_branch=0: D=1
  - EX_regwe=1 (not a load), matched, ID_branch=1: D=1
  - MEM load, matched, ID_branch=1: D=1
  - otherwise D=0
- FSM states and transitions:
  - RUN, D=0: no stall.
  - RUN, D≥1: stall asserted this cycle. If D=2, load remain=1 and go to HOLD. If D=1, stay in RUN.
  - HOLD: stall asserted unconditionally, with no re-evaluation. Decrement remain; at remain=0 return to RUN.
  - remain is a 1-bit down-counter.
- stall = (RUN && D≥1) || HOLD. PC_stall = IFID_stall = IDEX_flush = stall.
- IFID_flush = ID_taken && !stall. A taken branch is ignored while stalled because its operands are not valid; it is re-evaluated after the stall.
- IFID_stall and IFID_flush are never both 1.

## Timing
- Stall and flush outputs are combinational from inputs and state, valid in the same cycle as the hazard.
- State updates on the rising clk edge.
- Latency: a D-cycle hazard holds the pipeline for exactly D cycles, then proceeds with forwarding.
- Reset: while rst_n=0, all outputs are forced to 0. The next edge sets state=RUN, remain=0, stall_cnt=0, flush_cnt=0.
- Reset mid-HOLD: the next edge gives RUN. The remaining stall is abandoned; the upstream pipeline is reset too.
- ID_rs=ID_rt=matching register counts once.
- Register 0 never causes a stall.
- A hazard present while already in HOLD is not re-counted.

## Configuration
- HAZARD_STAT_EN defined:
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with IFID_flush=1.
  - Both wrap modulo 2^STAT_W with no saturation.
- HAZARD_STAT_EN not defined:
  - stall_cnt, flush_cnt and their registers are absent.
  - STAT_W is unused.
  - Hazard behaviour is unchanged.

## Test plan
- EX load to $8, ID add reads rs=$8 (use_rs=1, branch=0) -> stall=1 for exactly 1 cycle, IDEX_flush=1, state stays RUN; stall_cnt 0→1.
- EX load to $9, ID beq reads rt=$9 -> stall for 2 consecutive cycles (RUN→HOLD→RUN), inputs changed arbitrarily in cycle 2 have no effect; stall_cnt +2.
- EX add writes $3, ID beq rs=$3 -> 1 stall cycle; same case with ID_branch=0 -> no stall; ID source $0 against EX_RW=0 load -> no stall.
- ID_taken=1 with no hazard -> IFID_flush=1, PC_stall=0, flush_cnt +1. ID_taken=1 during a stall cycle -> IFID_flush=0.
- Reset asserted in HOLD cycle -> all outputs 0 during reset; next cycle state RUN, counters 0, no residual stall.
- HAZARD_STAT_EN with STAT_W=4: 17 stall cycles -> stall_cnt=1 (wrap).
